// File: rtl/pe_cfg_pkg.sv
// Shared types and constants for the PE configuration scheduler.
// It holds the scheduler FSM states and the layout of a configure-port word.
package pe_cfg_pkg;

   localparam int CFG_W         = 33;
   localparam int DATA_W        = 32;
   localparam int CFG_VALID_BIT = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } sched_state_e;

   // A configure-port word is the payload with the valid flag in the top bit.
   function automatic logic [CFG_W-1:0] make_cfg_word(input logic [DATA_W-1:0] data);
      return {1'b1, data};
   endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous word buffer with registered full/empty flags and a show-ahead read port.
// Pushes into a full buffer and pops from an empty buffer are ignored.
module cfg_word_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_pop_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_empty;

   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_nxt;

   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   // NOTE: storage is deliberately not reset; the empty flag keeps stale entries unreadable.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_full     = r_full;
   assign o_empty    = r_empty;

endmodule

// File: rtl/pe_cfg_sched.sv
// Buffers configuration words and streams them packet by packet onto per-PE configure ports,
// with idle gaps between packets and a done indication once a committed load has drained.
module pe_cfg_sched
   import pe_cfg_pkg::*;
#(
   parameter int NUM_PE = 2,
   parameter int DEPTH  = 8,
   parameter int GAP    = 1,
   localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_in_valid,
   output logic                    cfg_in_ready,
   input  logic [PE_W-1:0]         cfg_in_pe,
   input  logic [DATA_W-1:0]       cfg_in_data,
   input  logic                    cfg_in_last,
   input  logic                    cfg_commit,
   output logic [CFG_W*NUM_PE-1:0] pe_cfg_port,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   typedef struct packed {
      logic [PE_W-1:0]   pe;
      logic [DATA_W-1:0] data;
      logic              last;
   } cfg_entry_t;

   localparam int          ENT_W    = $bits(cfg_entry_t);
   localparam logic [2:0]  GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

   sched_state_e                  r_state;
   logic [NUM_PE-1:0][CFG_W-1:0]  r_port;
   logic [2:0]                    r_gap_cnt;
   logic                          r_done;
   logic                          r_err;
   logic                          r_pending;

   logic       w_accept;
   logic       w_pe_ok;
   logic       w_push;
   logic       w_pop;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   cfg_entry_t w_in_entry;
   cfg_entry_t w_head;

   assign w_accept   = cfg_in_valid && cfg_in_ready;
   assign w_pe_ok    = (32'(cfg_in_pe) < NUM_PE);
   assign w_push     = w_accept && w_pe_ok;
   assign w_pop      = ((r_state == ST_IDLE) || (r_state == ST_SEND)) && !w_fifo_empty;
   assign w_in_entry = '{pe: cfg_in_pe, data: cfg_in_data, last: cfg_in_last};

   cfg_word_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_in_entry),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_port    <= '0;
         r_gap_cnt <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (w_accept && !w_pe_ok) r_err <= 1'b1;

         // A commit marks the current load complete; any later word opens a new load.
         if (cfg_commit)    r_pending <= 1'b1;
         else if (w_accept) r_pending <= 1'b0;

         // NOTE: every slice defaults to zero each cycle so a word is valid for exactly one cycle.
         r_port <= '0;

         case (r_state)
            ST_IDLE, ST_SEND: begin
               if (!w_fifo_empty) begin
                  for (int k = 0; k < NUM_PE; k++) begin
                     if (PE_W'(k) == w_head.pe) r_port[k] <= make_cfg_word(w_head.data);
                  end
                  r_gap_cnt <= '0;
                  if (w_head.last) r_state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                  else             r_state <= ST_SEND;
               end else if (r_state == ST_IDLE && r_pending && !w_accept) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_LAST) r_state   <= ST_IDLE;
               else                       r_gap_cnt <= r_gap_cnt + 3'd1;
            end
            ST_DONE: begin
               if (w_accept) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cfg_in_ready = !w_fifo_full;
   assign pe_cfg_port  = r_port;
   assign busy         = (r_state == ST_SEND) || (r_state == ST_GAP) || !w_fifo_empty;
   assign done         = r_done;
   assign err          = r_err;

endmodule

// File: tb/tb_pe_cfg_sched.sv
// Scoreboard bench for pe_cfg_sched: the driver queues expected {pe, data, cycle}
// and a negedge monitor pops and compares whenever a valid word leaves a configure port.
module tb_pe_cfg_sched;

   localparam int NUM_PE = 3;
   localparam int DEPTH  = 8;
   localparam int GAP    = 1;
   localparam int PE_W   = 2;
   localparam int CW     = 33;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   cfg_in_valid;
   logic                   cfg_in_ready;
   logic [PE_W-1:0]        cfg_in_pe;
   logic [31:0]            cfg_in_data;
   logic                   cfg_in_last;
   logic                   cfg_commit;
   logic [CW*NUM_PE-1:0]   pe_cfg_port;
   logic                   busy;
   logic                   done;
   logic                   err;

   pe_cfg_sched #(
      .NUM_PE (NUM_PE),
      .DEPTH  (DEPTH),
      .GAP    (GAP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_in_valid (cfg_in_valid),
      .cfg_in_ready (cfg_in_ready),
      .cfg_in_pe    (cfg_in_pe),
      .cfg_in_data  (cfg_in_data),
      .cfg_in_last  (cfg_in_last),
      .cfg_commit   (cfg_commit),
      .pe_cfg_port  (pe_cfg_port),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          pe;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_err    = 0;
   int   n_stalls = 0;
   bit   mon_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input int pe, input logic [31:0] data, input bit last,
                            input bit commit, input bit expect_out, input int lat);
      int budget;
      budget       = 0;
      cfg_in_valid = 1'b1;
      cfg_in_pe    = PE_W'(pe);
      cfg_in_data  = data;
      cfg_in_last  = last;
      cfg_commit   = commit;
      while (!cfg_in_ready && budget < 50) begin
         step(1);
         budget++;
      end
      n_stalls += budget;
      if (!cfg_in_ready) check("ready_timeout", 64'(cfg_in_ready), 64'(1));
      if (expect_out) sb_q.push_back('{pe: pe, data: data, cyc: cyc + lat});
      step(1);
      cfg_in_valid = 1'b0;
      cfg_in_last  = 1'b0;
      cfg_commit   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int b;
      b = 0;
      while (!done && b < budget) begin
         step(1);
         b++;
      end
   endtask

   int          mon_nv;
   int          mon_idx;
   logic        mon_bad_idle;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (mon_en) begin
         mon_nv       = 0;
         mon_idx      = 0;
         mon_bad_idle = 1'b0;
         for (int k = 0; k < NUM_PE; k++) begin
            if (pe_cfg_port[k*CW+32]) begin
               mon_nv++;
               mon_idx = k;
            end else if (pe_cfg_port[k*CW +: CW] != '0) begin
               mon_bad_idle = 1'b1;
            end
         end
         if (mon_bad_idle) check("idle_slice_zero", 64'(mon_bad_idle), 64'(0));
         if (mon_nv > 0) begin
            check("one_slice_valid", 64'(mon_nv), 64'(1));
            if (sb_q.size() == 0) begin
               check("unexpected_word", 64'(sb_q.size()), 64'(1));
            end else begin
               mon_e = sb_q.pop_front();
               check("out_pe", 64'(mon_idx), 64'(mon_e.pe));
               check("out_data", 64'(pe_cfg_port[mon_idx*CW +: 32]), 64'(mon_e.data));
               check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      cfg_in_valid = 1'b0;
      cfg_in_pe    = '0;
      cfg_in_data  = '0;
      cfg_in_last  = 1'b0;
      cfg_commit   = 1'b0;
      step(2);
      reset = 1'b0;

      // Reset state
      check("rst_ready", 64'(cfg_in_ready), 64'(1));
      check("rst_busy",  64'(busy), 64'(0));
      check("rst_done",  64'(done), 64'(0));
      check("rst_err",   64'(err),  64'(0));
      check("rst_port",  64'(|pe_cfg_port), 64'(0));
      mon_en = 1'b1;

      // Three-word packet on PE0 with commit on the last word
      send_word(0, 32'h0AB5_A208, 1'b0, 1'b0, 1'b1, 2);
      send_word(0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 2);
      send_word(0, 32'h0000_0064, 1'b1, 1'b1, 1'b1, 2);
      wait_done(12);
      check("load_done", 64'(done), 64'(1));
      check("done_busy", 64'(busy), 64'(0));

      // One-word PE0 packet then two-word PE1 packet: one idle cycle between them
      send_word(0, 32'h1111_0000, 1'b1, 1'b0, 1'b1, 2);
      check("done_cleared", 64'(done), 64'(0));
      send_word(1, 32'h2222_0001, 1'b0, 1'b0, 1'b1, 3);
      send_word(1, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 3);
      check("busy_mid", 64'(busy), 64'(1));
      step(6);
      check("busy_idle", 64'(busy), 64'(0));
      check("no_done_wo_commit", 64'(done), 64'(0));

      // Out-of-range PE index between two good words
      check("err_before", 64'(err), 64'(0));
      send_word(2, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 2);
      send_word(3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0);
      send_word(2, 32'hCAFE_0002, 1'b1, 1'b0, 1'b1, 2);
      check("err_set", 64'(err), 64'(1));
      step(5);
      check("err_sticky", 64'(err), 64'(1));

      // DEPTH+3 back-to-back words of one packet
      n_stalls = 0;
      for (int i = 0; i < DEPTH + 3; i++)
         send_word(1, 32'h5000_0000 + 32'(i), (i == DEPTH + 2), 1'b0, 1'b1, 2);
      check("stream_no_stall", 64'(n_stalls), 64'(0));
      step(4);
      check("stream_busy_end", 64'(busy), 64'(0));

      // Reset while the second word of a three-word packet is being popped
      send_word(2, 32'h0000_00A0, 1'b0, 1'b0, 1'b1, 2);
      send_word(2, 32'h0000_00A1, 1'b0, 1'b0, 1'b0, 0);
      cfg_in_valid = 1'b1;
      cfg_in_pe    = 2'd2;
      cfg_in_data  = 32'h0000_00A2;
      cfg_in_last  = 1'b1;
      reset        = 1'b1;
      step(1);
      reset        = 1'b0;
      cfg_in_valid = 1'b0;
      cfg_in_last  = 1'b0;
      check("rstmid_port", 64'(|pe_cfg_port), 64'(0));
      check("rstmid_busy", 64'(busy), 64'(0));
      check("rstmid_ready", 64'(cfg_in_ready), 64'(1));
      check("rstmid_err", 64'(err), 64'(0));
      step(6);
      check("rstmid_quiet", 64'(busy), 64'(0));

      // Commit with an empty buffer, then a fresh word
      cfg_commit = 1'b1;
      step(1);
      cfg_commit = 1'b0;
      wait_done(2);
      check("commit_empty_done", 64'(done), 64'(1));
      check("commit_empty_busy", 64'(busy), 64'(0));
      send_word(1, 32'h0000_0077, 1'b1, 1'b0, 1'b1, 2);
      check("new_word_clears_done", 64'(done), 64'(0));

      begin
         int b;
         b = 0;
         while (sb_q.size() != 0 && b < 20) begin
            step(1);
            b++;
         end
      end
      step(3);
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
